// File: rtl/ddr5_pkg.sv
// Shared opcodes, CA field positions and types for the DDR5 device responder.
package ddr5_pkg;
    localparam int BEAT_W = 16;

    localparam logic [1:0] OPC_ACT = 2'b00;
    localparam logic [4:0] OPC_WR  = 5'b01101;
    localparam logic [4:0] OPC_RD  = 5'b11101;
    localparam logic [4:0] OPC_PRE = 5'b11011;

    localparam int CA_ROWA_LO = 2;
    localparam int CA_ROWA_HI = 5;
    localparam int CA_BA      = 6;
    localparam int CA_BG_HI   = 9;
    localparam int CA_PRE_ALL = 10;
    localparam int CA_ROWB_LO = 10;
    localparam int CA_ROWB_HI = 13;

    typedef logic [3:0] bank_t;

    typedef enum logic [2:0] {OP_BAD, OP_ACT, OP_WR, OP_RD, OP_PRE} op_e;
    typedef enum logic {ST_IDLE, ST_CMD2} cmd_state_e;

    function automatic op_e decode_op(input logic [4:0] ca);
        op_e op;
        if (ca[1:0] == OPC_ACT) op = OP_ACT;
        else if (ca == OPC_WR) op = OP_WR;
        else if (ca == OPC_RD) op = OP_RD;
        else if (ca == OPC_PRE) op = OP_PRE;
        else op = OP_BAD;
        return op;
    endfunction
endpackage

// File: rtl/ddr5_lat_pipe.sv
// Fixed-latency delay line carrying a valid flag and payload; output is the last stage.
module ddr5_lat_pipe
#(
    parameter int DEPTH = 63,
    parameter int W     = 32
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    logic [DEPTH-1:0] valid_r;
    logic [W-1:0]     data_r [DEPTH];

    // valid shift chain, cleared by reset so pending transfers are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
        end else begin
            valid_r[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) valid_r[i] <= valid_r[i-1];
        end
    end

    // payload shift chain
    always_ff @(posedge clk) begin
        data_r[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) data_r[i] <= data_r[i-1];
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_data  = data_r[DEPTH-1];
endmodule

// File: rtl/ddr5_dev_responder.sv
// DDR5 device-side responder: decodes CS/CA command packets, tracks open rows,
// captures write bursts and returns read bursts with fixed CL/CWL latency.
module ddr5_dev_responder
    import ddr5_pkg::*;
#(
    parameter int CL     = 20,
    parameter int CWL    = 20,
    parameter int BL     = 2,
    parameter int MEM_AW = 10,
    parameter int ROW_LB = 2,
    parameter int COL_LB = 4
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        CS,
    input  logic [13:0] CA,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        err_cmd,
    output logic        err_bus,
    output logic [15:0] bank_open
);
    localparam int WW = BL * BEAT_W;
    localparam int BW = (BL > 1) ? $clog2(BL) : 1;

    cmd_state_e        state_r, state_s;
    op_e               op1_s, op_r;
    bank_t             bank1_s, bank_r;
    logic [7:0]        row_lo_r;
    logic [15:0]       open_r;
    logic [15:0]       row_r [16];
    logic              cmd1_s, act_s, wr_s, rd_s, pre_s, err_s;
    logic [MEM_AW-1:0] idx_s;
    logic [WW-1:0]     mem_r [2**MEM_AW];

    logic              rd_tap_v, wr_tap_v;
    logic [WW-1:0]     rd_tap_d;
    logic [MEM_AW-1:0] wr_tap_d;

    logic              rd_busy_r;
    logic [BW-1:0]     rd_beat_r;
    logic [WW-1:0]     rd_word_r;

    logic              wr_busy_r, wr_act_s, wr_last_s;
    logic [BW-1:0]     wr_beat_r, wr_cur_s;
    logic [WW-1:0]     wr_buf_r, wr_word_s;
    logic [MEM_AW-1:0] wr_idx_r, wr_cur_idx_s;

    assign op1_s     = decode_op(CA[4:0]);
    assign bank1_s   = CA[CA_BG_HI:CA_BA];
    assign idx_s     = {bank_r, row_r[bank_r][ROW_LB-1:0], CA[COL_LB-1:0]};
    assign bank_open = open_r;

    // command framing state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // next-state and command strobes; cycle 2 with CS low drops the command
    always_comb begin
        state_s = state_r;
        cmd1_s  = 1'b0;
        act_s   = 1'b0;
        wr_s    = 1'b0;
        rd_s    = 1'b0;
        pre_s   = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!CS) begin
                    case (op1_s)
                        OP_ACT, OP_WR, OP_RD: begin
                            state_s = ST_CMD2;
                            cmd1_s  = 1'b1;
                        end
                        OP_PRE:  pre_s = 1'b1;
                        default: err_s = 1'b1;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMD2: begin
                state_s = ST_IDLE;
                if (!CS) begin
                    err_s = 1'b1;
                end else begin
                    case (op_r)
                        OP_ACT:  if (open_r[bank_r]) err_s = 1'b1; else act_s = 1'b1;
                        OP_WR:   if (open_r[bank_r]) wr_s = 1'b1;  else err_s = 1'b1;
                        OP_RD:   if (open_r[bank_r]) rd_s = 1'b1;  else err_s = 1'b1;
                        default: err_s = 1'b1;
                    endcase
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // cycle-1 latch, bank open flags and command error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r     <= OP_BAD;
            bank_r   <= '0;
            row_lo_r <= '0;
            open_r   <= '0;
            err_cmd  <= 1'b0;
        end else begin
            err_cmd <= err_s;
            if (cmd1_s) begin
                op_r     <= op1_s;
                bank_r   <= bank1_s;
                row_lo_r <= {CA[CA_ROWB_HI:CA_ROWB_LO], CA[CA_ROWA_HI:CA_ROWA_LO]};
            end
            if (pre_s) begin
                if (CA[CA_PRE_ALL]) open_r <= '0;
                else                open_r[bank1_s] <= 1'b0;
            end else if (act_s) begin
                open_r[bank_r] <= 1'b1;
            end
        end
    end

    // row table; only consulted while the bank is open
    always_ff @(posedge clk) begin
        if (act_s) row_r[bank_r] <= {CA[7:0], row_lo_r};
    end

    ddr5_lat_pipe #(.DEPTH(CL - 1), .W(WW)) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_s),
        .in_data   (mem_r[idx_s]),
        .out_valid (rd_tap_v),
        .out_data  (rd_tap_d)
    );

    ddr5_lat_pipe #(.DEPTH(CWL), .W(MEM_AW)) u_wr_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (wr_s),
        .in_data   (idx_s),
        .out_valid (wr_tap_v),
        .out_data  (wr_tap_d)
    );

    // read beat sequencer; a pipe hit starts beat 0 one cycle ahead of its slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_out    <= '0;
            dq_oe     <= 1'b0;
            err_bus   <= 1'b0;
            rd_busy_r <= 1'b0;
            rd_beat_r <= '0;
            rd_word_r <= '0;
        end else begin
            err_bus <= wr_act_s & dq_oe;
            if (rd_tap_v) begin
                dq_out    <= rd_tap_d[BEAT_W-1:0];
                dq_oe     <= 1'b1;
                rd_word_r <= rd_tap_d;
                rd_busy_r <= (BL > 1);
                rd_beat_r <= BW'(1);
            end else if (rd_busy_r) begin
                dq_out    <= rd_word_r[rd_beat_r*BEAT_W +: BEAT_W];
                dq_oe     <= 1'b1;
                rd_busy_r <= (rd_beat_r != BW'(BL - 1));
                rd_beat_r <= rd_beat_r + BW'(1);
            end else begin
                dq_out <= '0;
                dq_oe  <= 1'b0;
            end
        end
    end

    // current write beat: merge dq_in into the partially assembled word
    always_comb begin
        wr_act_s     = wr_tap_v | wr_busy_r;
        wr_cur_s     = wr_tap_v ? '0 : wr_beat_r;
        wr_cur_idx_s = wr_tap_v ? wr_tap_d : wr_idx_r;
        wr_word_s    = wr_buf_r;
        wr_word_s[wr_cur_s*BEAT_W +: BEAT_W] = dq_in;
        wr_last_s    = (wr_cur_s == BW'(BL - 1));
    end

    // write beat capture state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_busy_r <= 1'b0;
            wr_beat_r <= '0;
            wr_buf_r  <= '0;
            wr_idx_r  <= '0;
        end else if (wr_act_s) begin
            wr_buf_r  <= wr_word_s;
            wr_idx_r  <= wr_cur_idx_s;
            wr_busy_r <= !wr_last_s;
            wr_beat_r <= wr_last_s ? '0 : wr_cur_s + BW'(1);
        end
    end

    // storage commit on the last write beat
    always_ff @(posedge clk) begin
        if (wr_act_s && wr_last_s) mem_r[wr_cur_idx_s] <= wr_word_s;
    end
endmodule
